// File: rtl/pulse_width_stats.sv
// Pulse width statistics: synchronizes pulse_in, times each active pulse in clock
// cycles and keeps shortest/longest/most recent length, a pulse count and an overflow flag.
module pulse_width_stats #(
   parameter int N_BITS      = 8,
   parameter int CNT_BITS    = 16,
   parameter bit POLARITY    = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                pulse_in,
   output logic [N_BITS-1:0]   minimum,
   output logic [N_BITS-1:0]   maximum,
   output logic [N_BITS-1:0]   last,
   output logic [CNT_BITS-1:0] pulse_count,
   output logic                valid,
   output logic                overflow
);

   typedef enum logic [1:0] {ARM, IDLE, MEASURE} state_e;

   localparam logic INACTIVE = !POLARITY;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   active;
   logic                   primed;

   state_e                 state_q, state_d;
   logic [N_BITS-1:0]      len_q, len_d;
   logic                   sat_q, sat_d;
   logic [N_BITS-1:0]      min_q, min_d;
   logic [N_BITS-1:0]      max_q, max_d;
   logic [N_BITS-1:0]      last_q, last_d;
   logic [CNT_BITS-1:0]    cnt_q, cnt_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;

   // fill_q marks when the synchronizer holds real samples rather than its reset value,
   // so ARM cannot mistake the forced-inactive reset level for the end of a live pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{INACTIVE}};
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
         fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign active = (sync_q[SYNC_STAGES-1] == POLARITY);
   assign primed = fill_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      sat_d   = sat_q;
      min_d   = min_q;
      max_d   = max_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         ARM: begin
            if (primed && !active) state_d = IDLE;
         end
         IDLE: begin
            if (active) begin
               state_d = MEASURE;
               len_d   = N_BITS'(1);
               sat_d   = 1'b0;
            end
         end
         MEASURE: begin
            if (active) begin
               if (len_q == '1) sat_d = 1'b1;
               else             len_d = len_q + N_BITS'(1);
            end else begin
               // A saturated counter already reads all-ones, so len_q is the committed length.
               state_d = IDLE;
               last_d  = len_q;
               if (len_q < min_q) min_d = len_q;
               if (len_q > max_q) max_d = len_q;
               if (cnt_q != '1)   cnt_d = cnt_q + CNT_BITS'(1);
               valid_d = 1'b1;
               if (sat_q) ovf_d = 1'b1;
            end
         end
         default: state_d = ARM;
      endcase

      if (clear) begin
         state_d = ARM;
         len_d   = '0;
         sat_d   = 1'b0;
         min_d   = '1;
         max_d   = '0;
         last_d  = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARM;
         len_q   <= '0;
         sat_q   <= 1'b0;
         min_q   <= '1;
         max_q   <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         sat_q   <= sat_d;
         min_q   <= min_d;
         max_q   <= max_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign minimum     = min_q;
   assign maximum     = max_q;
   assign last        = last_q;
   assign pulse_count = cnt_q;
   assign valid       = valid_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_pulse_width_stats.sv
// Scoreboard bench for pulse_width_stats: a high-pulse instance and a low-pulse instance,
// expected statistics queued at each pulse fall and popped when the outputs change.
module tb_pulse_width_stats;

   typedef struct packed {
      logic [7:0]  lst;
      logic [7:0]  mn;
      logic [7:0]  mx;
      logic [15:0] cnt;
      logic        vld;
      logic        ovf;
   } snap_t;

   typedef struct {
      snap_t s;
      int    edge_n;
   } exp_t;

   localparam snap_t RST = '{lst: 8'd0, mn: 8'hFF, mx: 8'd0, cnt: 16'd0, vld: 1'b0, ovf: 1'b0};

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        clear_a = 1'b0;
   logic        clear_b = 1'b0;
   logic        pulse_a = 1'b1;
   logic        pulse_b = 1'b1;

   logic [7:0]  min_a, max_a, last_a, min_b, max_b, last_b;
   logic [15:0] cnt_a, cnt_b;
   logic        valid_a, ovf_a, valid_b, ovf_b;

   int          checks = 0;
   int          errors = 0;
   int          edge_cnt = 0;
   exp_t        q_a[$];
   exp_t        q_b[$];
   snap_t       prev_a = RST;
   snap_t       prev_b = RST;

   pulse_width_stats #(.N_BITS(8), .CNT_BITS(16), .POLARITY(1'b1), .SYNC_STAGES(2)) u_hi (
      .clk(clk), .reset_n(reset_n), .clear(clear_a), .pulse_in(pulse_a),
      .minimum(min_a), .maximum(max_a), .last(last_a), .pulse_count(cnt_a),
      .valid(valid_a), .overflow(ovf_a));

   pulse_width_stats #(.N_BITS(8), .CNT_BITS(16), .POLARITY(1'b0), .SYNC_STAGES(2)) u_lo (
      .clk(clk), .reset_n(reset_n), .clear(clear_b), .pulse_in(pulse_b),
      .minimum(min_b), .maximum(max_b), .last(last_b), .pulse_count(cnt_b),
      .valid(valid_b), .overflow(ovf_b));

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_snap(input string tag, input snap_t a, input snap_t e);
      chk({tag, "_last"},    int'(a.lst), int'(e.lst));
      chk({tag, "_minimum"}, int'(a.mn),  int'(e.mn));
      chk({tag, "_maximum"}, int'(a.mx),  int'(e.mx));
      chk({tag, "_count"},   int'(a.cnt), int'(e.cnt));
      chk({tag, "_valid"},   int'(a.vld), int'(e.vld));
      chk({tag, "_overflow"},int'(a.ovf), int'(e.ovf));
   endtask

   function automatic snap_t snap_a();
      return '{lst: last_a, mn: min_a, mx: max_a, cnt: cnt_a, vld: valid_a, ovf: ovf_a};
   endfunction

   function automatic snap_t snap_b();
      return '{lst: last_b, mn: min_b, mx: max_b, cnt: cnt_b, vld: valid_b, ovf: ovf_b};
   endfunction

   // Monitors: any output change is one DUT response, matched against the queue head.
   always @(negedge clk) begin
      snap_t cur;
      exp_t  e;
      cur = snap_a();
      if (!reset_n) prev_a = cur;
      else if (cur != prev_a) begin
         if (q_a.size() == 0) chk("hi_unexpected_change", 1, 0);
         else begin
            e = q_a.pop_front();
            chk("hi_update_edge", edge_cnt, e.edge_n);
            chk_snap("hi", cur, e.s);
         end
         prev_a = cur;
      end
   end

   always @(negedge clk) begin
      snap_t cur;
      exp_t  e;
      cur = snap_b();
      if (!reset_n) prev_b = cur;
      else if (cur != prev_b) begin
         if (q_b.size() == 0) chk("lo_unexpected_change", 1, 0);
         else begin
            e = q_b.pop_front();
            chk("lo_update_edge", edge_cnt, e.edge_n);
            chk_snap("lo", cur, e.s);
         end
         prev_b = cur;
      end
   end

   task automatic drive(input bit sel, input bit act);
      if (!sel) pulse_a = act;
      else      pulse_b = ~act;
   endtask

   // One pulse of len cycles, then gap inactive cycles; clr asserts clear on the commit edge.
   task automatic pulse(input bit sel, input int len, input int gap, input bit clr,
                        input int l, input int mn, input int mx, input int c, input bit o);
      exp_t e;
      drive(sel, 1'b1);
      repeat (len) @(negedge clk);
      drive(sel, 1'b0);
      e.edge_n = edge_cnt + 3;
      if (clr) e.s = RST;
      else     e.s = '{lst: 8'(l), mn: 8'(mn), mx: 8'(mx), cnt: 16'(c), vld: 1'b1, ovf: o};
      if (!sel) q_a.push_back(e);
      else      q_b.push_back(e);
      if (clr) begin
         repeat (2) @(negedge clk);
         clear_a = 1'b1;
         @(negedge clk);
         clear_a = 1'b0;
      end
      repeat (gap) @(negedge clk);
   endtask

   task automatic clear_stats_a();
      exp_t e;
      e.s = RST;
      e.edge_n = edge_cnt + 1;
      q_a.push_back(e);
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3 reset_n = 1'b0;
      #1 chk_snap("reset_hi", snap_a(), RST);

      // Release reset in the middle of a high pulse: it must be discarded.
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      pulse_a = 1'b0;
      repeat (8) @(negedge clk);
      chk("arm_valid",   int'(valid_a), 0);
      chk("arm_count",   int'(cnt_a),   0);
      chk("arm_minimum", int'(min_a),   255);
      chk("arm_maximum", int'(max_a),   0);

      pulse(1'b0, 5, 4, 1'b0,   5,   5,   5, 1, 1'b0);
      pulse(1'b0, 3, 4, 1'b0,   3,   3,   5, 2, 1'b0);
      pulse(1'b0, 9, 4, 1'b0,   9,   3,   9, 3, 1'b0);

      clear_stats_a();
      pulse(1'b0, 300, 4, 1'b0, 255, 255, 255, 1, 1'b1);
      pulse(1'b0, 4,   4, 1'b0,   4,   4, 255, 2, 1'b1);

      pulse(1'b0, 6, 4, 1'b1,   0,   0,   0, 0, 1'b0);
      pulse(1'b0, 2, 6, 1'b0,   2,   2,   2, 1, 1'b0);

      // Asynchronous reset between edges while a pulse is in flight.
      pulse_a = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk_snap("async_reset_hi", snap_a(), RST);
      @(negedge clk);
      pulse_a = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      pulse(1'b1, 7, 4, 1'b0, 7, 7, 7, 1, 1'b0);
      pulse(1'b1, 1, 1, 1'b0, 1, 1, 7, 2, 1'b0);
      pulse(1'b1, 2, 6, 1'b0, 2, 1, 7, 3, 1'b0);

      repeat (10) @(negedge clk);
      chk("hi_queue_drained", q_a.size(), 0);
      chk("lo_queue_drained", q_b.size(), 0);
      chk_snap("final_hi", snap_a(), RST);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_width_stats.md
PULSE_WIDTH_STATS -- requirements
Module: pulse_width_stats

Interface
REQ-001 The module SHALL have parameter N_BITS, default 8: width of every length value, in clock cycles.
REQ-002 The module SHALL have parameter CNT_BITS, default 16: width of the pulse counter.
REQ-003 The module SHALL have parameter POLARITY, default 1: active level of a pulse (1 = high pulses, 0 = low pulses).
REQ-004 The module SHALL have parameter SYNC_STAGES, default 2, minimum 2: number of synchronizer flops on pulse_in.
REQ-005 The module SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-006 The module SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port clear, input, 1 bit: synchronous statistics clear.
REQ-008 The module SHALL have port pulse_in, input, 1 bit: asynchronous pulse to measure.
REQ-009 The module SHALL have port minimum, output, N_BITS: shortest committed length.
REQ-010 The module SHALL have port maximum, output, N_BITS: longest committed length.
REQ-011 The module SHALL have port last, output, N_BITS: most recent committed length.
REQ-012 The module SHALL have port pulse_count, output, CNT_BITS: number of committed pulses.
REQ-013 The module SHALL have port valid, output, 1 bit: at least one pulse committed since reset or clear.
REQ-014 The module SHALL have port overflow, output, 1 bit: sticky flag, some pulse saturated the length counter.

Function
REQ-015 pulse_in SHALL pass through SYNC_STAGES flops; s denotes the synchronized value, and all behaviour below refers to s.
REQ-016 "Active" SHALL mean s == POLARITY.
REQ-017 The FSM SHALL have states ARM, IDLE and MEASURE.
- ARM waits for inactive.
- IDLE waits for active.
- MEASURE times the pulse.
REQ-018 ARM SHALL go to IDLE on an edge sampling s inactive, and otherwise hold; this discards a pulse already in progress at reset or clear.
REQ-019 IDLE SHALL go to MEASURE on an edge sampling s active, and SHALL load the length counter with 1.
REQ-020 MEASURE SHALL increment the length counter on each edge sampling s active, saturating at all-ones.
REQ-021 On the first edge in MEASURE sampling s inactive, the module SHALL commit and return to IDLE; measured length = number of edges that sampled s active.
REQ-022 At commit, last SHALL take the length.
REQ-023 At commit, minimum SHALL take the length if length < minimum, and maximum SHALL take the length if length > maximum; equal lengths leave both unchanged.
REQ-024 At commit, pulse_count SHALL increment, saturating at all-ones; valid SHALL be set to 1.
REQ-025 At commit, if the length counter saturated during that pulse, overflow SHALL be set to 1 and the committed length SHALL be all-ones.
REQ-026 All outputs SHALL be registered and change only at commit, clear or reset.
- Latency from a pulse_in trailing edge to updated outputs: SYNC_STAGES+1 clk edges.
REQ-027 Minimum measurable length SHALL be 1 cycle; back-to-back pulses separated by one inactive cycle SHALL each be committed.
REQ-028 clear SHALL act on the edge where it is sampled 1:
- minimum to all-ones, maximum, last, pulse_count to 0;
- valid, overflow to 0;
- length counter to 0;
- state to ARM.
REQ-029 clear SHALL take priority over a simultaneous commit, and that pulse SHALL be discarded.
REQ-030 While valid=0, minimum SHALL read all-ones and maximum SHALL read 0.

Reset
REQ-031 reset_n=0 SHALL immediately, without a clock edge, force:
- synchronizer flops to the inactive level;
- state to ARM;
- length counter 0, minimum all-ones;
- maximum, last, pulse_count 0;
- valid, overflow 0.
REQ-032 Deassertion of reset_n mid-pulse SHALL not produce a commit for that pulse (ARM rule).

Verification (N_BITS=8, CNT_BITS=16, SYNC_STAGES=2, POLARITY=1 unless stated)
REQ-033 The bench SHALL cover: release reset_n with pulse_in=1, hold 10 cycles, then 0 -> no commit; valid=0, pulse_count=0, minimum=255, maximum=0.
REQ-034 The bench SHALL cover: high pulses of 5, 3, 9 cycles, 4 low cycles apart.
- last = 5/3/9; minimum = 5/3/3; maximum = 5/5/9.
- pulse_count = 1/2/3; valid = 1 from first commit.
- Each update lands exactly 3 edges after the pulse_in fall.
REQ-035 The bench SHALL cover: a 300-cycle high pulse -> last=255, maximum=255, overflow=1, pulse_count incremented; a following 4-cycle pulse -> minimum=4, overflow stays 1.
REQ-036 The bench SHALL cover: clear asserted on the commit edge of a 6-cycle pulse -> all statistics at reset values, pulse discarded; the next 2-cycle pulse yields last=2, minimum=maximum=2, pulse_count=1.
REQ-037 The bench SHALL cover a POLARITY=0 instance: 7-cycle low pulse -> last=7; 1-cycle low pulse -> minimum=1, maximum=7.
REQ-038 The bench SHALL cover: reset_n asserted mid-pulse between clock edges -> all outputs at reset values before the next clk edge.
